// File: rtl/lieat_exu_vpu_vseq_pkg.sv
// ============================================================================
// Module      : lieat_exu_vpu_vseq_pkg
// Description : Shared VPU types: sequencer state encoding, register geometry
//               and the vunit op-select bundle layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lieat_exu_vpu_vseq_pkg;

  localparam int VPU_XLEN  = 32;
  localparam int VPU_VLEN  = 128;
  localparam int VPU_NELEM = VPU_VLEN / VPU_XLEN;

  typedef enum logic [1:0] {
    VSEQ_IDLE = 2'd0,
    VSEQ_RUN  = 2'd1,
    VSEQ_DONE = 2'd2
  } vseq_state_e;

  // Bit order matches the lieat_exu_vpu_vunit32 op-select inputs.
  typedef struct packed {
    logic vadd;
    logic vsub;
    logic vrsub;
  } vpu_op_t;

endpackage

`default_nettype wire

// File: rtl/lieat_exu_vpu_velem_sel.sv
// ============================================================================
// Module      : lieat_exu_vpu_velem_sel
// Description : Combinational mux picking element idx_i out of a packed vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lieat_exu_vpu_velem_sel #(
  parameter int XLEN  = 32,
  parameter int VLEN  = 128,
  parameter int IW    = 2
) (
  input  logic [VLEN-1:0] vec_i,
  input  logic [IW-1:0]   idx_i,
  output logic [XLEN-1:0] elem_o
);

  localparam int NELEM = VLEN / XLEN;

  always_comb begin
    elem_o = '0;
    for (int e = 0; e < NELEM; e++) begin
      if (idx_i == IW'(e)) begin
        elem_o = vec_i[e*XLEN +: XLEN];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lieat_exu_vpu_vseq.sv
// ============================================================================
// Module      : lieat_exu_vpu_vseq
// Description : Element sequencer feeding the 32-bit vector ALU one element per
//               cycle and reassembling a whole-register add/sub/rsub result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lieat_exu_vpu_vseq
  import lieat_exu_vpu_vseq_pkg::*;
#(
  parameter  int XLEN  = VPU_XLEN,
  parameter  int VLEN  = VPU_VLEN,
  localparam int NELEM = VLEN / XLEN,
  localparam int VLW   = $clog2(NELEM) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            seq_i_valid,
  output logic            seq_i_ready,
  input  logic [VLEN-1:0] seq_i_vs1,
  input  logic [VLEN-1:0] seq_i_vs2,
  input  logic [XLEN-1:0] seq_i_rs1,
  input  logic            seq_i_vx,
  input  logic [VLW-1:0]  seq_i_vl,
  input  logic            seq_i_vadd,
  input  logic            seq_i_vsub,
  input  logic            seq_i_vrsub,
  output logic            vunit_valid,
  output logic [XLEN-1:0] vunit_op1,
  output logic [XLEN-1:0] vunit_op2,
  output logic            vunit_vadd,
  output logic            vunit_vsub,
  output logic            vunit_vrsub,
  input  logic            vunit_o_valid,
  input  logic [XLEN-1:0] vunit_o_data,
  output logic            seq_o_valid,
  input  logic            seq_o_ready,
  output logic [VLEN-1:0] seq_o_data
);

  localparam int IW = (NELEM > 1) ? $clog2(NELEM) : 1;

  vseq_state_e     state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [VLW-1:0]  vl_q, vl_d;
  vpu_op_t         op_q, op_d;
  logic            vx_q, vx_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [VLEN-1:0] vs1_q, vs1_d;
  logic [VLEN-1:0] vs2_q, vs2_d;
  logic [VLEN-1:0] result_q, result_d;

  logic            accept;
  logic            last_elem;
  logic [VLW-1:0]  vl_clamp;
  logic [XLEN-1:0] vs1_elem;
  logic [XLEN-1:0] vs2_elem;

  assign accept    = (state_q == VSEQ_IDLE) && seq_i_valid;
  assign vl_clamp  = (seq_i_vl > VLW'(NELEM)) ? VLW'(NELEM) : seq_i_vl;
  assign last_elem = (VLW'(idx_q) == (vl_q - VLW'(1)));

  lieat_exu_vpu_velem_sel #(.XLEN(XLEN), .VLEN(VLEN), .IW(IW)) u_sel_vs1 (
    .vec_i  (vs1_q),
    .idx_i  (idx_q),
    .elem_o (vs1_elem)
  );

  lieat_exu_vpu_velem_sel #(.XLEN(XLEN), .VLEN(VLEN), .IW(IW)) u_sel_vs2 (
    .vec_i  (vs2_q),
    .idx_i  (idx_q),
    .elem_o (vs2_elem)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= VSEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      VSEQ_IDLE: if (seq_i_valid) state_d = (vl_clamp != '0) ? VSEQ_RUN : VSEQ_DONE;
      VSEQ_RUN:  if (vunit_o_valid && last_elem) state_d = VSEQ_DONE;
      VSEQ_DONE: if (seq_o_ready) state_d = VSEQ_IDLE;
      default:   state_d = VSEQ_IDLE;
    endcase
  end

  always_comb begin
    seq_i_ready = 1'b0;
    vunit_valid = 1'b0;
    vunit_op1   = '0;
    vunit_op2   = '0;
    vunit_vadd  = 1'b0;
    vunit_vsub  = 1'b0;
    vunit_vrsub = 1'b0;
    seq_o_valid = 1'b0;
    seq_o_data  = '0;
    case (state_q)
      VSEQ_IDLE: seq_i_ready = 1'b1;
      VSEQ_RUN: begin
        vunit_valid = 1'b1;
        vunit_op1   = vs2_elem;
        vunit_op2   = vx_q ? rs1_q : vs1_elem;
        vunit_vadd  = op_q.vadd;
        vunit_vsub  = op_q.vsub;
        vunit_vrsub = op_q.vrsub;
      end
      VSEQ_DONE: begin
        seq_o_valid = 1'b1;
        seq_o_data  = result_q;
      end
      default: ;
    endcase
  end

  // Result buffer is zeroed at acceptance so tail elements read back as 0.
  always_comb begin
    idx_d    = idx_q;
    vl_d     = vl_q;
    op_d     = op_q;
    vx_d     = vx_q;
    rs1_d    = rs1_q;
    vs1_d    = vs1_q;
    vs2_d    = vs2_q;
    result_d = result_q;
    if (accept) begin
      idx_d    = '0;
      vl_d     = vl_clamp;
      op_d     = '{vadd: seq_i_vadd, vsub: seq_i_vsub, vrsub: seq_i_vrsub};
      vx_d     = seq_i_vx;
      rs1_d    = seq_i_rs1;
      vs1_d    = seq_i_vs1;
      vs2_d    = seq_i_vs2;
      result_d = '0;
    end else if ((state_q == VSEQ_RUN) && vunit_o_valid) begin
      idx_d = idx_q + IW'(1);
      for (int e = 0; e < NELEM; e++) begin
        if (idx_q == IW'(e)) begin
          result_d[e*XLEN +: XLEN] = vunit_o_data;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q    <= '0;
      vl_q     <= '0;
      op_q     <= '0;
      vx_q     <= 1'b0;
      rs1_q    <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      result_q <= '0;
    end else begin
      idx_q    <= idx_d;
      vl_q     <= vl_d;
      op_q     <= op_d;
      vx_q     <= vx_d;
      rs1_q    <= rs1_d;
      vs1_q    <= vs1_d;
      vs2_q    <= vs2_d;
      result_q <= result_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lieat_exu_vpu_vseq.sv
// ============================================================================
// Module      : tb_lieat_exu_vpu_vseq
// Description : Self-checking bench for the vector element sequencer with a
//               combinational vunit stand-in and a whole-register reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lieat_exu_vpu_vseq;

  logic         clock;
  logic         reset;
  logic         seq_i_valid;
  logic         seq_i_ready;
  logic [127:0] seq_i_vs1;
  logic [127:0] seq_i_vs2;
  logic [31:0]  seq_i_rs1;
  logic         seq_i_vx;
  logic [2:0]   seq_i_vl;
  logic         seq_i_vadd;
  logic         seq_i_vsub;
  logic         seq_i_vrsub;
  logic         vunit_valid;
  logic [31:0]  vunit_op1;
  logic [31:0]  vunit_op2;
  logic         vunit_vadd;
  logic         vunit_vsub;
  logic         vunit_vrsub;
  logic         vunit_o_valid;
  logic [31:0]  vunit_o_data;
  logic         seq_o_valid;
  logic         seq_o_ready;
  logic [127:0] seq_o_data;

  int n_chk = 0;
  int n_err = 0;

  lieat_exu_vpu_vseq dut (
    .clock         (clock),
    .reset         (reset),
    .seq_i_valid   (seq_i_valid),
    .seq_i_ready   (seq_i_ready),
    .seq_i_vs1     (seq_i_vs1),
    .seq_i_vs2     (seq_i_vs2),
    .seq_i_rs1     (seq_i_rs1),
    .seq_i_vx      (seq_i_vx),
    .seq_i_vl      (seq_i_vl),
    .seq_i_vadd    (seq_i_vadd),
    .seq_i_vsub    (seq_i_vsub),
    .seq_i_vrsub   (seq_i_vrsub),
    .vunit_valid   (vunit_valid),
    .vunit_op1     (vunit_op1),
    .vunit_op2     (vunit_op2),
    .vunit_vadd    (vunit_vadd),
    .vunit_vsub    (vunit_vsub),
    .vunit_vrsub   (vunit_vrsub),
    .vunit_o_valid (vunit_o_valid),
    .vunit_o_data  (vunit_o_data),
    .seq_o_valid   (seq_o_valid),
    .seq_o_ready   (seq_o_ready),
    .seq_o_data    (seq_o_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational stand-in for the 32-bit vector ALU.
  always_comb begin
    case ({vunit_vadd, vunit_vsub, vunit_vrsub})
      3'b100:  vunit_o_data = vunit_op1 + vunit_op2;
      3'b010:  vunit_o_data = vunit_op1 - vunit_op2;
      3'b001:  vunit_o_data = vunit_op2 - vunit_op1;
      default: vunit_o_data = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // vd[i] = vs2[i] op (vx ? rs1 : vs1[i]) for i < min(vl,4); remaining elements 0.
  function automatic logic [127:0] model(input logic [127:0] vs1, input logic [127:0] vs2,
                                         input logic [31:0] rs1, input bit vx,
                                         input int vl, input logic [2:0] op);
    logic [127:0] r;
    logic [31:0]  a, b, e;
    int           n;
    r = '0;
    n = (vl > 4) ? 4 : vl;
    for (int i = 0; i < n; i++) begin
      a = vs2[i*32 +: 32];
      b = vx ? rs1 : vs1[i*32 +: 32];
      case (op)
        3'b100:  e = a + b;
        3'b010:  e = a - b;
        3'b001:  e = b - a;
        default: e = 32'd0;
      endcase
      r[i*32 +: 32] = e;
    end
    return r;
  endfunction

  task automatic drive_op(input logic [127:0] vs1, input logic [127:0] vs2,
                          input logic [31:0] rs1, input bit vx, input logic [2:0] vl,
                          input logic [2:0] op);
    seq_i_valid = 1'b1;
    seq_i_vs1   = vs1;
    seq_i_vs2   = vs2;
    seq_i_rs1   = rs1;
    seq_i_vx    = vx;
    seq_i_vl    = vl;
    {seq_i_vadd, seq_i_vsub, seq_i_vrsub} = op;
  endtask

  task automatic run_op(input string tag, input logic [127:0] vs1, input logic [127:0] vs2,
                        input logic [31:0] rs1, input bit vx, input logic [2:0] vl,
                        input logic [2:0] op, input int stall_cyc, input bit rnd_stall,
                        input int rdy_delay);
    logic [127:0] exp;
    logic [31:0]  exp_op2;
    int           n, k, cyc, nv;
    bit           got;
    exp = model(vs1, vs2, rs1, vx, int'(vl), op);
    n   = (vl > 3'd4) ? 4 : int'(vl);
    @(negedge clock);
    seq_o_ready = 1'b0;
    drive_op(vs1, vs2, rs1, vx, vl, op);
    chk({tag, "/in_ready"}, 128'(seq_i_ready), 128'd1);
    @(posedge clock);
    @(negedge clock);
    seq_i_valid = 1'b0;
    cyc = 1; k = 0; nv = 0; got = 1'b0;
    while (cyc < 200) begin
      if (seq_o_valid) begin
        got = 1'b1;
        break;
      end
      vunit_o_valid = !((cyc == stall_cyc) || (rnd_stall && ($urandom_range(0, 3) == 0)));
      chk({tag, "/issuing"}, 128'(vunit_valid), 128'd1);
      chk({tag, "/in_ready_busy"}, 128'(seq_i_ready), 128'd0);
      if (vunit_valid) begin
        nv++;
        if (k < n) begin
          exp_op2 = vx ? rs1 : vs1[k*32 +: 32];
          chk({tag, "/op1"}, 128'(vunit_op1), 128'(vs2[k*32 +: 32]));
          chk({tag, "/op2"}, 128'(vunit_op2), 128'(exp_op2));
          chk({tag, "/opsel"}, 128'({vunit_vadd, vunit_vsub, vunit_vrsub}), 128'(op));
        end else begin
          chk({tag, "/extra_issue"}, 128'(k), 128'(n - 1));
        end
        if (vunit_o_valid) k++;
      end
      @(negedge clock);
      cyc++;
    end
    vunit_o_valid = 1'b1;
    chk({tag, "/done_seen"}, 128'(got), 128'd1);
    if (!got) return;
    chk({tag, "/n_elem"}, 128'(k), 128'(n));
    chk({tag, "/latency"}, 128'(cyc), 128'(nv + 1));
    chk({tag, "/no_issue_done"}, 128'(vunit_valid), 128'd0);
    for (int d = 0; d < rdy_delay; d++) begin
      chk({tag, "/hold_data"}, seq_o_data, exp);
      chk({tag, "/hold_valid"}, 128'(seq_o_valid), 128'd1);
      chk({tag, "/hold_in_ready"}, 128'(seq_i_ready), 128'd0);
      @(negedge clock);
    end
    seq_o_ready = 1'b1;
    chk({tag, "/data"}, seq_o_data, exp);
    chk({tag, "/out_valid"}, 128'(seq_o_valid), 128'd1);
    @(negedge clock);
    seq_o_ready = 1'b0;
    chk({tag, "/idle_ready"}, 128'(seq_i_ready), 128'd1);
    chk({tag, "/idle_out_valid"}, 128'(seq_o_valid), 128'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "/in_ready"}, 128'(seq_i_ready), 128'd1);
    chk({tag, "/vvalid"}, 128'(vunit_valid), 128'd0);
    chk({tag, "/op1"}, 128'(vunit_op1), 128'd0);
    chk({tag, "/op2"}, 128'(vunit_op2), 128'd0);
    chk({tag, "/opsel"}, 128'({vunit_vadd, vunit_vsub, vunit_vrsub}), 128'd0);
    chk({tag, "/ovalid"}, 128'(seq_o_valid), 128'd0);
    chk({tag, "/odata"}, seq_o_data, 128'd0);
  endtask

  initial begin
    logic [127:0] r1, r2;
    logic [2:0]   op;
    reset         = 1'b0;
    seq_i_valid   = 1'b0;
    seq_i_vs1     = '0;
    seq_i_vs2     = '0;
    seq_i_rs1     = '0;
    seq_i_vx      = 1'b0;
    seq_i_vl      = '0;
    seq_i_vadd    = 1'b0;
    seq_i_vsub    = 1'b0;
    seq_i_vrsub   = 1'b0;
    vunit_o_valid = 1'b1;
    seq_o_ready   = 1'b0;
    repeat (2) @(negedge clock);
    chk_quiet("reset");
    reset = 1'b1;

    run_op("vadd", {32'd40, 32'd30, 32'd20, 32'd10}, {32'd4, 32'd3, 32'd2, 32'd1},
           32'd0, 1'b0, 3'd4, 3'b100, -1, 1'b0, 0);
    run_op("vsub_vx", '0, {4{32'd5}}, 32'd7, 1'b1, 3'd4, 3'b010, -1, 1'b0, 0);
    run_op("vrsub", {32'd1, 32'd1, 32'd100, 32'd3}, {4{32'd9}},
           32'd0, 1'b0, 3'd2, 3'b001, -1, 1'b0, 0);
    run_op("vl0", {4{32'hDEAD_BEEF}}, {4{32'h1234_5678}}, 32'd0, 1'b0, 3'd0, 3'b100, -1, 1'b0, 0);
    run_op("vl7", {32'd8, 32'd7, 32'd6, 32'd5}, {32'd1, 32'd2, 32'd3, 32'd4},
           32'd0, 1'b0, 3'd7, 3'b100, -1, 1'b0, 0);
    run_op("backpressure", {32'd1, 32'd2, 32'd3, 32'd4}, {32'd10, 32'd20, 32'd30, 32'd40},
           32'd0, 1'b0, 3'd4, 3'b010, 2, 1'b0, 3);
    run_op("nosel", {4{32'd3}}, {4{32'd6}}, 32'd0, 1'b0, 3'd4, 3'b000, -1, 1'b0, 0);

    // Abort during the second RUN cycle; outputs must drop immediately.
    @(negedge clock);
    drive_op({4{32'd1}}, {4{32'd2}}, 32'd0, 1'b0, 3'd4, 3'b100);
    @(posedge clock);
    @(negedge clock);
    seq_i_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_quiet("abort");
    @(negedge clock);
    reset = 1'b1;
    run_op("after_abort", {32'd7, 32'd6, 32'd5, 32'd4}, {32'd100, 32'd200, 32'd300, 32'd400},
           32'd0, 1'b0, 3'd3, 3'b001, -1, 1'b0, 1);

    for (int t = 0; t < 40; t++) begin
      r1 = {$urandom, $urandom, $urandom, $urandom};
      r2 = {$urandom, $urandom, $urandom, $urandom};
      op = 3'(1 << $urandom_range(0, 2));
      run_op($sformatf("rnd%0d", t), r1, r2, $urandom, 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), op, -1, 1'b1, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

`default_nettype wire
